// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port 1K x 32 data memory; DMEM_ARB_FIXED_PRIO_EN selects fixed priority to port 1.
// Latency: handshake in T, memory access in T+1, registered rsp pulse in T+2; one access per 2 cycles sustained.
// Backpressure: reqN_ready is high only for the IDLE-cycle winner; requests wait (or may be withdrawn) until then.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addrs,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_gnt;
  logic                r_last;
  logic                r_rsp0_valid;
  logic                r_rsp1_valid;
  logic [DATA_W-1:0]   r_rsp0_rdata;
  logic [DATA_W-1:0]   r_rsp1_rdata;

  logic                w_win;
  logic                w_hs;
  logic                w_rdy0;
  logic                w_rdy1;
  logic                w_mem_read;
  logic                w_mem_write;

  // Winner when both are valid; a lone requester always wins.
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign w_win = req1_valid;
`else
  assign w_win = (req0_valid && req1_valid) ? ~r_last : req1_valid;
`endif

  always_comb begin
    w_next_state = r_state;
    w_hs         = 1'b0;
    w_rdy0       = 1'b0;
    w_rdy1       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          w_hs         = 1'b1;
          w_rdy0       = ~w_win;
          w_rdy1       = w_win;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Reset low during the access suppresses the memory strobe so no write commits.
        w_mem_read   = rst_n & ~r_we;
        w_mem_write  = rst_n & r_we;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_gnt        <= 1'b0;
      r_last       <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_state      <= w_next_state;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (w_hs) begin
        r_addr  <= w_win ? req1_addr  : req0_addr;
        r_we    <= w_win ? req1_we    : req0_we;
        r_wdata <= w_win ? req1_wdata : req0_wdata;
        r_gnt   <= w_win;
        r_last  <= w_win;
      end
      if (r_state == S_ACCESS) begin
        if (r_gnt) begin
          r_rsp1_valid <= 1'b1;
          if (!r_we) r_rsp1_rdata <= read_data;
        end else begin
          r_rsp0_valid <= 1'b1;
          if (!r_we) r_rsp0_rdata <= read_data;
        end
      end
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;
  assign mem_addrs  = r_addr;
  assign write_data = r_wdata;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign busy       = (r_state == S_ACCESS);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 1K x 32 data memory.
- Requester 0 is the instruction-fetch / loader port; requester 1 is the load/store unit.
- Accepts one request at a time over a valid/ready handshake, drives the memory's mem_addrs/mem_read/mem_write/write_data for one access cycle, then returns a registered response pulse to the winning port.
- The memory writes on the clk posedge and its read_data is combinational from mem_addrs.

Parameters:
ADDR_W, 10, word-address width; equals memory mem_addrs width
DATA_W, 32, data width; equals memory write_data/read_data width

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_we  input  1  port 0: 1 = write, 0 = read
req0_addr  input  ADDR_W  port 0 word address
req0_wdata  input  DATA_W  port 0 write data
rsp0_valid  output  1  port 0 response pulse; one cycle
rsp0_rdata  output  DATA_W  port 0 read data; valid when rsp0_valid
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
mem_addrs  output  ADDR_W  to memory address
mem_read  output  1  to memory read enable
mem_write  output  1  to memory write enable
write_data  output  DATA_W  to memory write data
read_data  input  DATA_W  from memory, combinational read
busy  output  1  high while state is ACCESS

Behaviour:
- FSM states are IDLE and ACCESS. Reset state is IDLE.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_rdata = rsp1_rdata = 0.
  - Latched address, we, wdata and grant id are all 0.
  - last_grant = 1, so port 0 wins the first tie.
- In reset/IDLE, mem_read = mem_write = 0; mem_addrs and write_data drive the latched registers.
- IDLE:
  - If any reqN_valid is high, pick a winner. With a single requester, it wins. With both requesters, the winner is the port that is not last_grant.
  - reqN_ready is high combinationally only for the winner, in the same cycle. req ready is never high in ACCESS.
  - On the handshake edge, latch addr, we, wdata and the grant id, set last_grant = winner, and go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addrs = latched addr, mem_write = latched we, mem_read = ~latched we, write_data = latched wdata.
  - A write commits at the posedge closing this cycle.
  - For a read, read_data is captured into rspN_rdata of the granted port at that edge.
  - For a write, rspN_rdata holds its previous value.
  - rspN_valid of the granted port is set for the next cycle only (acknowledges both reads and writes). Go to IDLE.
- Latency and throughput:
  - Handshake in cycle T, memory access in T+1, rspN_valid high in T+2.
  - A new handshake may occur in T+2, the same cycle as the response. Sustained throughput is one access per 2 cycles.
- rspN_valid is never high for both ports in the same cycle. rspN_rdata is stable until the next read response on that port.
- Requesters must hold valid/addr/we/wdata stable until ready. Deasserting valid before ready is allowed and drops the request without side effects.
- Address is a word index. ADDR_W-bit values are used unmodified; there is no wrap or overflow logic.
- Reset mid-operation:
  - If rst_n is low during an ACCESS cycle, mem_write and mem_read are forced to 0 combinationally, so the write does not commit.
  - No rsp_valid is produced and the state returns to IDLE.
  - Reset held low in IDLE forces req ready low.
- Simultaneous events: a new valid arriving on the losing port while the other port is in ACCESS waits. It is granted in the next IDLE ahead of the port that just finished, if both are valid.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- When defined, replaces round-robin with fixed priority: port 1 (load/store) always wins when both are valid. last_grant is still updated but ignored.
- When undefined, round-robin as above.
- All other timing is identical either way.

Test Plan:
- Reset, then single write: port 1 writes 0x12345678 to addr 10 -> req1_ready high in handshake cycle; mem_write=1 with mem_addrs=10 exactly one cycle later; rsp1_valid pulse 2 cycles after handshake.
- Read-back: port 0 reads addr 10 -> rsp0_valid pulse with rsp0_rdata=0x12345678; mem_read=1, mem_write=0 during ACCESS.
- Contention: both ports valid continuously, port 0 reading addr 20, port 1 writing 0xDEADBEEF to addr 20.
  - Round-robin: port 0 wins first and gets the old value at addr 20; then port 1 writes; then port 0 reads again and gets 0xDEADBEEF. Grants alternate 0,1,0,1.
  - With DMEM_ARB_FIXED_PRIO_EN: port 1 granted every IDLE cycle while valid; port 0 waits until req1_valid drops.
- Back-to-back: 4 reads from port 1 (addrs 1..4) held valid -> handshakes every 2nd cycle; rsp1_valid pulses in cycles 2,4,6,8 after the first handshake, each with the correct data.
- Reset mid-write: assert rst_n=0 during the ACCESS cycle of a write of 0xCAFEF00D to addr 30 -> mem_write stays 0, no rsp pulse; a later read of addr 30 returns the prior contents.
- Early valid drop: req0_valid pulsed for one cycle while port 1 is in ACCESS -> no grant to port 0, no memory access for it, no rsp0_valid.
